pwrmgr_slow_wake_ctrl: RTL
==========================

// Module: pwrmgr_slow_wake_ctrl
// PURPOSE
// Slow-clock-domain wakeup/reset request front end of the power manager; directly feeds
// wakeup_i/reset_req_i of the slow power FSM. Synchronises raw peripheral wakeup and reset
// requests, optionally glitch-filters wakeups, masks them by enables, arms only while the
// chip is in low power, and latches which source(s) caused the wake for software readback.
// PARAMETERS
// NumWkups      4  number of peripheral wakeup sources
// NumRstReqs    2  number of peripheral reset request sources
// FilterCycles  4  consecutive high slow-clock cycles required by a filtered wakeup (>=2)
// PORTS
// clk_i              in   1           slow (AON) clock
// rst_ni             in   1           asynchronous, active-low reset
// wakeup_req_i       in   NumWkups    raw async wakeup requests (level)
// wakeup_en_i        in   NumWkups    per-source wakeup enable (quasi-static)
// wakeup_filter_en_i in   NumWkups    per-source filter enable (quasi-static)
// rst_req_i          in   NumRstReqs  raw async reset requests (level)
// rst_en_i           in   NumRstReqs  per-source reset enable
// low_power_i        in   1           1 while slow FSM is in its low-power state
// wake_info_clr_i    in   1           single-cycle pulse: clear captured wake info
// wakeup_o           out  1           registered wakeup to slow FSM
// reset_req_o        out  1           registered reset request to slow FSM
// wake_info_o        out  NumWkups    sticky capture of wakeup sources that fired
// wake_info_rst_o    out  1           sticky: a reset request caused the exit
// BEHAVIOUR
// - Reset: all outputs 0, all filter counters 0, FSM = WkIdle, sync flops 0.
// - Every raw input passes a 2-flop synchroniser (outputs treated as async).
// - Filter (per source, if filter_en): counter counts up while synced input=1, saturates at
//   FilterCycles, clears to 0 on any synced 0; filtered=1 only when counter==FilterCycles.
//   filter_en=0: filtered = synced input. Counter keeps running regardless of filter_en.
// - masked_wk = filtered & wakeup_en_i; masked_rst = synced rst & rst_en_i (never filtered).
// - Latency raw rise -> wakeup_o: 3 cycles unfiltered; 2+FilterCycles+1 filtered.
//   raw rise -> reset_req_o: 3 cycles.
// - FSM (wakeup path):
//   WkIdle : wakeup_o=0. low_power_i=1 -> WkArmed.
//   WkArmed: |masked_wk -> wake_info |= masked_wk, wakeup_o<=1, -> WkHold.
//            low_power_i=0 with no wake (reset exit) -> WkIdle.
//   WkHold : wakeup_o held 1; low_power_i=0 -> wakeup_o<=0, -> WkIdle.
//   Invalid encoding -> WkIdle, outputs 0 (defensive default).
// - Wakeups while not in low power are ignored (no capture, no output).
// - Reset path independent of FSM: reset_req_o <= |masked_rst every cycle, any state;
//   when |masked_rst & low_power_i, wake_info_rst_o <= 1.
// - Simultaneous wake+reset in WkArmed: both outputs assert same cycle, both captured;
//   slow FSM gives reset cause priority.
// - Only the first wake event per low-power episode is captured; later sources in WkHold
//   are not added. wake_info is sticky across episodes until cleared.
// - wake_info_clr_i clears wake_info_o and wake_info_rst_o next cycle; a capture in the same
//   cycle wins (the new bits are set, older bits cleared).
// - Enable dropping in WkHold does not drop wakeup_o (held until low_power_i falls).
// - Async reset mid-episode returns to WkIdle and clears captured info.
// STRUCTURE
// - pwrmgr_pkg: slow_wk_state_e (WkIdle, WkArmed, WkHold; sparse encoding), NumWkups,
//   NumRstReqs defaults.
// - Sub-module pwrmgr_wake_filter: one instance per wakeup source (sync + counter + filter).
//   Reset requests use prim_flop_2sync directly.
// TESTING
// 1 low_power_i=1, en[1]=1, filt off, raise req[1] -> wakeup_o=1 at cycle 3, info=4'b0010.
// 2 filter_en[0]=1, req[0] high 3 cycles then low -> no wakeup_o; high 4+ cycles ->
//   wakeup_o at cycle 2+4+1=7, info[0]=1.
// 3 low_power_i=0, req[2]=1 en[2]=1 -> wakeup_o stays 0, info stays 0; then low_power_i=1
//   -> wakeup_o=1 within 2 cycles, info[2]=1.
// 4 WkArmed, req[3] and rst_req[0] rise same cycle, enabled -> wakeup_o and reset_req_o both
//   1 same cycle, info=4'b1000, wake_info_rst_o=1.
// 5 info=4'b0010, clr pulse coincident with new capture of src 0 -> info=4'b0001.
// 6 assert rst_ni low in WkHold -> all outputs 0 immediately, FSM=WkIdle after release.

Source files
------------

// File: rtl/pwrmgr_pkg.sv
// Shared types and defaults for the power manager slow-domain wake front end.
package pwrmgr_pkg;

  localparam int unsigned NumWkupsDefault     = 4;
  localparam int unsigned NumRstReqsDefault   = 2;
  localparam int unsigned FilterCyclesDefault = 4;

  // One-hot so a single flipped bit always lands on an illegal code.
  typedef enum logic [2:0] {
    WkIdle  = 3'b001,
    WkArmed = 3'b010,
    WkHold  = 3'b100
  } slow_wk_state_e;

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for level signals crossing into the slow clock domain.
module prim_flop_2sync #(
  parameter int unsigned Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      q_o    <= ResetValue;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/pwrmgr_wake_filter.sv
// Per-source wakeup synchroniser plus optional consecutive-high glitch filter.
module pwrmgr_wake_filter #(
  parameter int unsigned FilterCycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic filter_en_i,
  output logic filtered_o
);

  localparam int unsigned CntW = $clog2(FilterCycles + 1);

  logic           req_sync;
  logic [CntW-1:0] cnt_q;

  prim_flop_2sync #(.Width(1)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (req_i),
    .q_o    (req_sync)
  );

  // Counter runs even when filtering is off so enabling it later sees true history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!req_sync) begin
      cnt_q <= '0;
    end else if (cnt_q != CntW'(FilterCycles)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign filtered_o = filter_en_i ? (cnt_q == CntW'(FilterCycles)) : req_sync;

endmodule

// File: rtl/pwrmgr_slow_wake_ctrl.sv
// Slow-domain wakeup/reset request front end: sync, filter, mask, arm in low power, capture cause.
//   state   | meaning
//   WkIdle  | not in low power, wakeups ignored, wakeup_o low
//   WkArmed | in low power, waiting for the first enabled wakeup
//   WkHold  | wakeup issued and held until low_power_i falls
module pwrmgr_slow_wake_ctrl
  import pwrmgr_pkg::*;
#(
  parameter int unsigned NumWkups     = NumWkupsDefault,
  parameter int unsigned NumRstReqs   = NumRstReqsDefault,
  parameter int unsigned FilterCycles = FilterCyclesDefault
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumWkups-1:0]   wakeup_req_i,
  input  logic [NumWkups-1:0]   wakeup_en_i,
  input  logic [NumWkups-1:0]   wakeup_filter_en_i,
  input  logic [NumRstReqs-1:0] rst_req_i,
  input  logic [NumRstReqs-1:0] rst_en_i,
  input  logic                  low_power_i,
  input  logic                  wake_info_clr_i,
  output logic                  wakeup_o,
  output logic                  reset_req_o,
  output logic [NumWkups-1:0]   wake_info_o,
  output logic                  wake_info_rst_o
);

  logic [NumWkups-1:0]   wk_filtered;
  logic [NumWkups-1:0]   masked_wk;
  logic [NumRstReqs-1:0] rst_sync;
  logic                  rst_any;
  slow_wk_state_e        state_q;

  for (genvar i = 0; i < NumWkups; i++) begin : g_wk
    pwrmgr_wake_filter #(.FilterCycles(FilterCycles)) u_filter (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (wakeup_req_i[i]),
      .filter_en_i (wakeup_filter_en_i[i]),
      .filtered_o  (wk_filtered[i])
    );
  end

  prim_flop_2sync #(.Width(NumRstReqs)) u_rst_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rst_req_i),
    .q_o    (rst_sync)
  );

  assign masked_wk = wk_filtered & wakeup_en_i;
  assign rst_any   = |(rst_sync & rst_en_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= WkIdle;
      wakeup_o        <= 1'b0;
      reset_req_o     <= 1'b0;
      wake_info_o     <= '0;
      wake_info_rst_o <= 1'b0;
    end else begin
      reset_req_o <= rst_any;
      if (rst_any && low_power_i) begin
        wake_info_rst_o <= 1'b1;
      end else if (wake_info_clr_i) begin
        wake_info_rst_o <= 1'b0;
      end
      if (wake_info_clr_i) begin
        wake_info_o <= '0;
      end

      case (state_q)
        WkIdle: begin
          wakeup_o <= 1'b0;
          if (low_power_i) state_q <= WkArmed;
        end
        WkArmed: begin
          if (|masked_wk) begin
            // Capture beats a coincident clear: only the older bits are dropped.
            wake_info_o <= (wake_info_clr_i ? '0 : wake_info_o) | masked_wk;
            wakeup_o    <= 1'b1;
            state_q     <= WkHold;
          end else if (!low_power_i) begin
            state_q <= WkIdle;
          end
        end
        WkHold: begin
          if (!low_power_i) begin
            wakeup_o <= 1'b0;
            state_q  <= WkIdle;
          end
        end
        default: begin
          wakeup_o <= 1'b0;
          state_q  <= WkIdle;
        end
      endcase
    end
  end

endmodule
